// File: rtl/sfft_reader_pkg.sv
// rtl/sfft_reader_pkg.sv - shared scanner states, register map and status packing for the SFFT frame reader
`ifndef SFFT_OUTPUT_WIDTH
`define SFFT_OUTPUT_WIDTH 16
`endif

package sfft_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scanState_t;

  // Register offsets above the bin window (address = NFFT + offset)
  localparam int STATUS_OFS  = 0;
  localparam int PEAKBIN_OFS = 1;
  localparam int PEAKMAG_OFS = 2;
  localparam int ACK_OFS     = 3;

  // STATUS word layout
  localparam int ST_AVAIL_BIT    = 0;
  localparam int ST_SCANNING_BIT = 1;
  localparam int ST_OVERRUN_LSB  = 8;
  localparam int ST_SEQ_LSB      = 16;

  function automatic logic [31:0] packStatus(input logic [15:0] seq, input logic [7:0] overrun,
                                             input logic scanning, input logic avail);
    logic [31:0] s;
    s = '0;
    s[ST_SEQ_LSB +: 16]    = seq;
    s[ST_OVERRUN_LSB +: 8] = overrun;
    s[ST_SCANNING_BIT]     = scanning;
    s[ST_AVAIL_BIT]        = avail;
    return s;
  endfunction

endpackage

// File: rtl/sfft_frame_reader_if.sv
// rtl/sfft_frame_reader_if.sv - Avalon-MM slave register bus of the SFFT frame reader
interface sfft_frame_reader_if #(
  parameter int ADDR_W = 10
);
  logic              chipselect;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (
    output chipselect, read, write, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, read, write, address, writedata,
    output readdata
  );
endinterface

// File: rtl/sfft_frame_reader_peak_scanner.sv
// rtl/sfft_frame_reader_peak_scanner.sv - walks the lower half of the back bank and latches the peak-magnitude bin
module sfft_peak_scanner #(
  parameter int NFFT   = 512,
  parameter int DATA_W = 16,
  parameter int IDX_W  = $clog2(NFFT) - 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] binData,
  output logic [IDX_W-1:0]         scanIdx,
  output logic                     scanning,
  output logic                     done,
  output logic [IDX_W-1:0]         peakBin,
  output logic [DATA_W-1:0]        peakMag
);
  import sfft_reader_pkg::*;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NFFT / 2 - 1);
  localparam logic [DATA_W-1:0] MAG_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_PAT  = {1'b1, {(DATA_W-1){1'b0}}};

  scanState_t        state;
  scanState_t        nextState;
  logic [DATA_W-1:0] binMag;
  logic [DATA_W-1:0] curMax;
  logic [DATA_W-1:0] nextMax;
  logic [IDX_W-1:0]  curBin;
  logic [IDX_W-1:0]  nextBin;

  // Scanner state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // A new frame always restarts the scan; an ack parks the scanner
  always_comb begin
    nextState = state;
    if (start) begin
      nextState = SCAN;
    end else if (clear) begin
      nextState = IDLE;
    end else begin
      case (state)
        SCAN:    if (scanIdx == LAST_IDX) nextState = DONE;
        default: nextState = state;
      endcase
    end
  end

  // Status outputs decoded from the state
  always_comb begin
    scanning = (state == SCAN);
    done     = (state == DONE);
  end

  // Magnitude with the most-negative code clamped to the largest positive value
  always_comb begin
    binMag = '0;
    if ($unsigned(binData) == MIN_PAT) binMag = MAG_MAX;
    else if (binData < 0)              binMag = $unsigned(-binData);
    else                               binMag = $unsigned(binData);
  end

  // Strict greater-than keeps the lowest index on ties
  always_comb begin
    nextMax = curMax;
    nextBin = curBin;
    if (binMag > curMax) begin
      nextMax = binMag;
      nextBin = scanIdx;
    end
  end

  // Index walk, running maximum and the latched result of the last full scan
  always_ff @(posedge clk) begin
    if (reset) begin
      scanIdx <= '0;
      curMax  <= '0;
      curBin  <= '0;
      peakBin <= '0;
      peakMag <= '0;
    end else if (start) begin
      scanIdx <= '0;
      curMax  <= '0;
      curBin  <= '0;
    end else if (state == SCAN) begin
      scanIdx <= scanIdx + 1'b1;
      curMax  <= nextMax;
      curBin  <= nextBin;
      if (scanIdx == LAST_IDX) begin
        peakBin <= nextBin;
        peakMag <= nextMax;
      end
    end
  end

endmodule

// File: rtl/sfft_frame_reader.sv
// rtl/sfft_frame_reader.sv - ping-pong capture of SFFT frames with peak scan and Avalon-MM readout
module sfft_frame_reader #(
  parameter int NFFT   = 512,
  parameter int DATA_W = `SFFT_OUTPUT_WIDTH,
  parameter int ADDR_W = $clog2(NFFT) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] sfft_in [NFFT],
  input  logic                     sfft_valid,
  sfft_frame_reader_if.slave       bus,
  output logic                     irq
);
  import sfft_reader_pkg::*;

  localparam int LOG_N = $clog2(NFFT);
  localparam int IDX_W = LOG_N - 1;
  localparam logic [ADDR_W-1:0] ACK_ADDR = ADDR_W'(NFFT + ACK_OFS);

  logic signed [DATA_W-1:0] bank [2][NFFT];
  logic                     rdSel;
  logic                     pending;
  logic [7:0]               overrun;
  logic [15:0]              seq;
  logic [IDX_W-1:0]         frontPeakBin;
  logic [DATA_W-1:0]        frontPeakMag;
  logic [IDX_W-1:0]         backPeakBin;
  logic [DATA_W-1:0]        backPeakMag;
  logic [IDX_W-1:0]         scanIdx;
  logic signed [DATA_W-1:0] scanBin;
  logic                     scanning;
  logic                     scanDone;
  logic                     frameAvail;
  logic                     ackFire;
  logic                     wrBank;
  logic [ADDR_W-1:0]        addr;
  logic [LOG_N-1:0]         binAddr;
  logic [31:0]              readNext;
  logic                     unusedWriteBits;

  assign addr            = bus.address;
  assign binAddr         = addr[LOG_N-1:0];
  assign frameAvail      = pending && scanDone;
  assign irq             = frameAvail;
  assign unusedWriteBits = ^bus.writedata[31:1];
  assign ackFire = bus.chipselect && bus.write && (addr == ACK_ADDR) && bus.writedata[0] && frameAvail;
  // When ack and capture coincide the swap happens first, so the frame lands in the old front bank
  assign wrBank  = ackFire ? rdSel : ~rdSel;
  assign scanBin = bank[~rdSel][{1'b0, scanIdx}];

  sfft_peak_scanner #(
    .NFFT   (NFFT),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) peakScanner (
    .clk      (clk),
    .reset    (reset),
    .start    (sfft_valid),
    .clear    (ackFire),
    .binData  (scanBin),
    .scanIdx  (scanIdx),
    .scanning (scanning),
    .done     (scanDone),
    .peakBin  (backPeakBin),
    .peakMag  (backPeakMag)
  );

  // Capture the whole frame into the back bank in one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NFFT; i++)
          bank[b][i] <= '0;
    end else if (sfft_valid) begin
      for (int i = 0; i < NFFT; i++)
        bank[wrBank][i] <= sfft_in[i];
    end
  end

  // Bank ownership, frame bookkeeping and the software-visible peak copy
  always_ff @(posedge clk) begin
    if (reset) begin
      rdSel        <= 1'b0;
      pending      <= 1'b0;
      overrun      <= '0;
      seq          <= '0;
      frontPeakBin <= '0;
      frontPeakMag <= '0;
    end else begin
      if (ackFire) begin
        rdSel        <= ~rdSel;
        seq          <= seq + 16'd1;
        frontPeakBin <= backPeakBin;
        frontPeakMag <= backPeakMag;
      end
      if (sfft_valid) begin
        pending <= 1'b1;
        if (pending && !ackFire && (overrun != 8'hFF)) overrun <= overrun + 8'd1;
      end else if (ackFire) begin
        pending <= 1'b0;
      end
    end
  end

  // Read decode: bin window below NFFT, small register block above it
  always_comb begin
    readNext = '0;
    if (!addr[LOG_N]) begin
      readNext = 32'(bank[rdSel][binAddr]);
    end else if (binAddr == LOG_N'(STATUS_OFS)) begin
      readNext = packStatus(seq, overrun, scanning, frameAvail);
    end else if (binAddr == LOG_N'(PEAKBIN_OFS)) begin
      readNext = 32'(frontPeakBin);
    end else if (binAddr == LOG_N'(PEAKMAG_OFS)) begin
      readNext = 32'(frontPeakMag);
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge clk) begin
    if (reset)                              bus.readdata <= '0;
    else if (bus.chipselect && bus.read)    bus.readdata <= readNext;
  end

endmodule

// File: tb/tb_sfft_frame_reader.sv
// tb/tb_sfft_frame_reader.sv - randomized self-checking bench for sfft_frame_reader
`timescale 1ns/1ps
module tb_sfft_frame_reader;
  localparam int NFFT   = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int HALF   = NFFT / 2;
  localparam int MIN_INT = int'(32'h80000000);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [DATA_W-1:0] sfftIn [NFFT];
  logic sfftValid = 1'b0;
  logic irq;

  int total = 0;
  int bad = 0;

  sfft_frame_reader_if #(.ADDR_W(ADDR_W)) bus();

  sfft_frame_reader #(.NFFT(NFFT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sfft_in    (sfftIn),
    .sfft_valid (sfftValid),
    .bus        (bus),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // reference model state
  int frame [NFFT];
  int mFront [NFFT];
  int mBack [NFFT];
  bit mPending;
  int mSeq, mOverrun, mScanLeft, mFBin, mFMag, mBBin, mBMag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit mAvail();
    return mPending && (mScanLeft == 0);
  endfunction

  function automatic void peakOf(input int f [NFFT], output int pb, output int pm);
    pb = 0;
    pm = 0;
    for (int i = 0; i < HALF; i++) begin
      int m;
      if (f[i] == MIN_INT) m = 32'h7FFFFFFF;
      else if (f[i] < 0)   m = -f[i];
      else                 m = f[i];
      if (m > pm) begin
        pm = m;
        pb = i;
      end
    end
  endfunction

  function automatic logic [31:0] modelRead(input int a);
    if (a < NFFT)     return mFront[a];
    if (a == NFFT)    return {mSeq[15:0], mOverrun[7:0], 6'b0, (mScanLeft > 0), mAvail()};
    if (a == NFFT+1)  return mFBin;
    if (a == NFFT+2)  return mFMag;
    return 32'h0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NFFT; i++) begin
      mFront[i] = 0;
      mBack[i]  = 0;
    end
    mPending = 0; mSeq = 0; mOverrun = 0; mScanLeft = 0;
    mFBin = 0; mFMag = 0; mBBin = 0; mBMag = 0;
  endtask

  task automatic modelEdge(input bit valid, input bit ackHit);
    if (ackHit && mAvail()) begin
      for (int i = 0; i < NFFT; i++) begin
        int t;
        t = mFront[i];
        mFront[i] = mBack[i];
        mBack[i] = t;
      end
      mFBin = mBBin;
      mFMag = mBMag;
      mSeq = (mSeq + 1) & 16'hFFFF;
      mPending = 0;
    end
    if (valid) begin
      if (mPending && mOverrun < 255) mOverrun++;
      mBack = frame;
      peakOf(frame, mBBin, mBMag);
      mPending = 1;
      mScanLeft = HALF;
    end else if (mScanLeft > 0) begin
      mScanLeft--;
    end
  endtask

  // one clock: drive, advance the model, check irq and (optionally) readdata
  task automatic step(input bit valid, input bit ackWr, input logic [31:0] wd, input bit rd, input int a);
    logic [31:0] exp;
    int useAddr;
    useAddr = ackWr ? NFFT + 3 : a;
    exp = modelRead(useAddr);
    sfftValid = valid;
    for (int i = 0; i < NFFT; i++) sfftIn[i] = valid ? frame[i] : $urandom;
    bus.chipselect = ackWr | rd;
    bus.write      = ackWr;
    bus.read       = rd;
    bus.address    = ADDR_W'(useAddr);
    bus.writedata  = wd;
    @(posedge clk);
    modelEdge(valid, ackWr && wd[0]);
    #1;
    check("irq", 32'(irq), 32'(mAvail()));
    if (rd) check($sformatf("read@%0d", useAddr), bus.readdata, exp);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
  endtask

  task automatic capture();
    step(1'b1, 1'b0, 32'h0, 1'b0, 0);
  endtask

  task automatic ack();
    step(1'b0, 1'b1, 32'h1, 1'b0, 0);
  endtask

  task automatic readAt(input int a);
    step(1'b0, 1'b0, 32'h0, 1'b1, a);
  endtask

  task automatic waitIrq(output int n);
    n = 0;
    while (!irq && n < 20) begin
      idle();
      n++;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    sfftValid = 1'b0;
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.address = '0; bus.writedata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    check("rstReaddata", bus.readdata, 32'h0);
    check("rstIrq", 32'(irq), 32'h0);
  endtask

  task automatic randFrame(input bit smallVals);
    for (int i = 0; i < NFFT; i++) begin
      if ($urandom_range(0, 7) == 0) frame[i] = MIN_INT;
      else if (smallVals)            frame[i] = int'($urandom_range(0, 12)) - 6;
      else                           frame[i] = int'($urandom);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < NFFT; i++) begin
      frame[i] = 0;
      sfftIn[i] = '0;
    end
    doReset();

    // 1: empty state after reset
    readAt(NFFT);
    check("statusAfterReset", bus.readdata, 32'h0);
    for (int a = 0; a < NFFT; a++) readAt(a);

    // 2: first frame, latency, ack and readback
    frame = '{5, -9, 3, 1, 0, 0, 0, 0};
    capture();
    waitIrq(n);
    check("irqLatency", 32'(n), 32'd4);
    readAt(0);
    check("frontBeforeAck", bus.readdata, 32'h0);
    ack();
    readAt(1);
    check("bin1", bus.readdata, 32'hFFFFFFF7);
    readAt(NFFT + 1);
    check("peakBin", bus.readdata, 32'd1);
    readAt(NFFT + 2);
    check("peakMag", bus.readdata, 32'd9);
    readAt(NFFT);
    check("seqAfterAck", 32'(bus.readdata[31:16]), 32'd1);

    // 3: ties keep lowest index; upper half ignored; most-negative saturates
    frame = '{7, -7, 7, 0, 100, 100, 100, 100};
    capture();
    waitIrq(n);
    ack();
    readAt(NFFT + 1);
    check("tieBin", bus.readdata, 32'd0);
    readAt(NFFT + 2);
    check("tieMag", bus.readdata, 32'd7);
    frame = '{MIN_INT, 5, -3, 2, 0, 0, 0, 0};
    capture();
    waitIrq(n);
    ack();
    readAt(NFFT + 2);
    check("minIntMag", bus.readdata, 32'h7FFFFFFF);

    // 4: overrun, newest frame wins, saturation
    frame = '{11, 12, 13, 14, 15, 16, 17, 18};
    capture();
    frame = '{21, 22, 23, 24, 25, 26, 27, 28};
    capture();
    readAt(NFFT);
    check("overrunOne", 32'(bus.readdata[15:8]), 32'd1);
    waitIrq(n);
    ack();
    readAt(0);
    check("newestWins", bus.readdata, 32'd21);
    for (int k = 0; k < 257; k++) begin
      randFrame(1'b0);
      capture();
    end
    readAt(NFFT);
    check("overrunSat", 32'(bus.readdata[15:8]), 32'hFF);

    // 5: ack in the same cycle as a new frame
    doReset();
    frame = '{31, 32, 33, 34, 35, 36, 37, 38};
    capture();
    waitIrq(n);
    frame = '{41, 42, 43, 44, 45, 46, 47, 48};
    step(1'b1, 1'b1, 32'h1, 1'b0, 0);
    waitIrq(n);
    check("ackValidLatency", 32'(n), 32'd4);
    readAt(0);
    check("ackValidFront", bus.readdata, 32'd31);
    readAt(NFFT);
    check("ackValidOverrun", 32'(bus.readdata[15:8]), 32'd0);

    // 6: reset mid-scan, then a stray ack, then a normal frame
    doReset();
    frame = '{1, 2, 3, 4, 5, 6, 7, 8};
    capture();
    idle();
    idle();
    doReset();
    readAt(NFFT);
    check("statusMidScanReset", bus.readdata, 32'h0);
    ack();
    readAt(NFFT);
    check("strayAckSeq", 32'(bus.readdata[31:16]), 32'd0);
    capture();
    waitIrq(n);
    check("postResetLatency", 32'(n), 32'd4);

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      bit v, w, r;
      v = ($urandom_range(0, 5) == 0);
      w = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) != 0);
      if (v) randFrame($urandom_range(0, 1) == 1);
      step(v, w, w ? (($urandom_range(0, 3) == 0) ? 32'h2 : $urandom | 32'h1) : 32'h0,
           r, $urandom_range(0, 15));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
